// File: rtl/rggen_avalon_adapter.sv
// rggen_avalon_adapter: Avalon-MM slave front end for rggen register blocks.
// Accepts one Avalon transfer at a time, drives it onto the rggen register
// bus and returns the result as a pipelined Avalon response.
// Optional feature macro: RGGEN_AVALON_ADAPTER_TIMEOUT_EN. When it is defined,
// a BUSY watchdog forces a SLVERR completion after TIMEOUT_CYCLES cycles.
module rggen_avalon_adapter #(
  parameter int ADDRESS_WIDTH  = 8,
  parameter int BUS_WIDTH      = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_read,
  input  logic                     i_write,
  input  logic [ADDRESS_WIDTH-1:0] i_address,
  input  logic [BUS_WIDTH/8-1:0]   i_byteenable,
  input  logic [BUS_WIDTH-1:0]     i_writedata,
  output logic                     o_waitrequest,
  output logic                     o_readdatavalid,
  output logic                     o_writeresponsevalid,
  output logic [1:0]               o_response,
  output logic [BUS_WIDTH-1:0]     o_readdata,
  output logic                     o_bus_valid,
  output logic [1:0]               o_bus_access,
  output logic [ADDRESS_WIDTH-1:0] o_bus_address,
  output logic [BUS_WIDTH-1:0]     o_bus_write_data,
  output logic [BUS_WIDTH/8-1:0]   o_bus_strobe,
  input  logic                     i_bus_ready,
  input  logic [1:0]               i_bus_status,
  input  logic [BUS_WIDTH-1:0]     i_bus_read_data
);

  localparam logic [1:0] RGGEN_READ  = 2'b10;
  localparam logic [1:0] RGGEN_WRITE = 2'b11;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // The watchdog counter is 16 bits wide, so the threshold must fit in it.
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("rggen_avalon_adapter: TIMEOUT_CYCLES out of range 1..65535");
  end

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t r_state;
  state_t w_next_state;
  logic   w_accept;
  logic   w_done;
  logic   w_timeout;
  logic   w_complete;

  logic                     r_readdatavalid;
  logic                     r_writeresponsevalid;
  logic [1:0]               r_response;
  logic [BUS_WIDTH-1:0]     r_readdata;
  logic [1:0]               r_bus_access;
  logic [ADDRESS_WIDTH-1:0] r_bus_address;
  logic [BUS_WIDTH-1:0]     r_bus_write_data;
  logic [BUS_WIDTH/8-1:0]   r_bus_strobe;

`ifdef RGGEN_AVALON_ADAPTER_TIMEOUT_EN
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] r_timeout_cnt;

  // Ready in the expiry cycle takes priority, so expiry requires !i_bus_ready.
  assign w_timeout = (r_state == BUSY) && !i_bus_ready && (r_timeout_cnt == TIMEOUT_LAST);

  // Watchdog: cleared on accept, counts each BUSY cycle spent waiting for ready.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_timeout_cnt <= '0;
    end else if (w_accept) begin
      r_timeout_cnt <= '0;
    end else if ((r_state == BUSY) && !i_bus_ready) begin
      r_timeout_cnt <= r_timeout_cnt + 16'd1;
    end
  end
`else
  assign w_timeout = 1'b0;
`endif

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state decode: accept only in IDLE, leave BUSY on ready or expiry.
  always_comb begin
    w_next_state = r_state;
    w_accept     = 1'b0;
    w_done       = 1'b0;
    w_complete   = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_read || i_write) begin
          w_accept     = 1'b1;
          w_next_state = BUSY;
        end
      end
      BUSY: begin
        w_done     = i_bus_ready;
        w_complete = i_bus_ready || w_timeout;
        if (w_complete) begin
          w_next_state = IDLE;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  // Capture the accepted request; it stays frozen on the rggen bus while BUSY.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_bus_access     <= RGGEN_READ;
      r_bus_address    <= '0;
      r_bus_write_data <= '0;
      r_bus_strobe     <= '0;
    end else if (w_accept) begin
      r_bus_access     <= i_write ? RGGEN_WRITE : RGGEN_READ;
      r_bus_address    <= i_address;
      r_bus_write_data <= i_writedata;
      r_bus_strobe     <= i_byteenable;
    end
  end

  // Response path: one-cycle completion pulse, status and read data held after it.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_readdatavalid      <= 1'b0;
      r_writeresponsevalid <= 1'b0;
      r_response           <= 2'b00;
      r_readdata           <= '0;
    end else begin
      r_readdatavalid      <= w_complete && (r_bus_access == RGGEN_READ);
      r_writeresponsevalid <= w_complete && (r_bus_access == RGGEN_WRITE);
      if (w_done) begin
        r_response <= i_bus_status;
        if (r_bus_access == RGGEN_READ) begin
          r_readdata <= i_bus_read_data;
        end
      end else if (w_timeout) begin
        r_response <= RESP_SLVERR;
        if (r_bus_access == RGGEN_READ) begin
          r_readdata <= '0;
        end
      end
    end
  end

  assign o_waitrequest        = (r_state == BUSY);
  assign o_bus_valid          = (r_state == BUSY);
  assign o_readdatavalid      = r_readdatavalid;
  assign o_writeresponsevalid = r_writeresponsevalid;
  assign o_response           = r_response;
  assign o_readdata           = r_readdata;
  assign o_bus_access         = r_bus_access;
  assign o_bus_address        = r_bus_address;
  assign o_bus_write_data     = r_bus_write_data;
  assign o_bus_strobe         = r_bus_strobe;

endmodule

// File: tb/tb_rggen_avalon_adapter.sv
// Directed bench for rggen_avalon_adapter. The timeout scenario is built only
// when RGGEN_AVALON_ADAPTER_TIMEOUT_EN is defined (DUT uses TIMEOUT_CYCLES = 4).
module tb_rggen_avalon_adapter;

  localparam int AW = 8;
  localparam int DW = 32;
  localparam logic [1:0] RD = 2'b10;
  localparam logic [1:0] WR = 2'b11;

  logic          i_clk = 1'b0;
  logic          i_rst_n;
  logic          i_read;
  logic          i_write;
  logic [AW-1:0] i_address;
  logic [3:0]    i_byteenable;
  logic [DW-1:0] i_writedata;
  logic          o_waitrequest;
  logic          o_readdatavalid;
  logic          o_writeresponsevalid;
  logic [1:0]    o_response;
  logic [DW-1:0] o_readdata;
  logic          o_bus_valid;
  logic [1:0]    o_bus_access;
  logic [AW-1:0] o_bus_address;
  logic [DW-1:0] o_bus_write_data;
  logic [3:0]    o_bus_strobe;
  logic          i_bus_ready;
  logic [1:0]    i_bus_status;
  logic [DW-1:0] i_bus_read_data;

  int n_vec = 0;
  int n_err = 0;

  rggen_avalon_adapter #(
    .ADDRESS_WIDTH (AW),
    .BUS_WIDTH     (DW),
    .TIMEOUT_CYCLES(4)
  ) dut (
    .i_clk               (i_clk),
    .i_rst_n             (i_rst_n),
    .i_read              (i_read),
    .i_write             (i_write),
    .i_address           (i_address),
    .i_byteenable        (i_byteenable),
    .i_writedata         (i_writedata),
    .o_waitrequest       (o_waitrequest),
    .o_readdatavalid     (o_readdatavalid),
    .o_writeresponsevalid(o_writeresponsevalid),
    .o_response          (o_response),
    .o_readdata          (o_readdata),
    .o_bus_valid         (o_bus_valid),
    .o_bus_access        (o_bus_access),
    .o_bus_address       (o_bus_address),
    .o_bus_write_data    (o_bus_write_data),
    .o_bus_strobe        (o_bus_strobe),
    .i_bus_ready         (i_bus_ready),
    .i_bus_status        (i_bus_status),
    .i_bus_read_data     (i_bus_read_data)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle; outputs are then sampled and inputs driven 1 time unit after the edge.
  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, ".waitreq"}, o_waitrequest, 0);
    chk({tag, ".bus_valid"}, o_bus_valid, 0);
    chk({tag, ".rvalid"}, o_readdatavalid, 0);
    chk({tag, ".wvalid"}, o_writeresponsevalid, 0);
    chk({tag, ".resp"}, o_response, 2'b00);
    chk({tag, ".rdata"}, o_readdata, 0);
    chk({tag, ".access"}, o_bus_access, RD);
    chk({tag, ".addr"}, o_bus_address, 0);
    chk({tag, ".wdata"}, o_bus_write_data, 0);
    chk({tag, ".strobe"}, o_bus_strobe, 0);
  endtask

  initial begin
    i_rst_n = 1'b0; i_read = 1'b0; i_write = 1'b0; i_address = '0;
    i_byteenable = '0; i_writedata = '0; i_bus_ready = 1'b0;
    i_bus_status = 2'b00; i_bus_read_data = '0;

    // Reset state
    tick(); tick();
    chk_reset_outputs("rst");
    i_rst_n = 1'b1;
    tick();
    chk("idle.waitreq", o_waitrequest, 0);

    // Read 0x10, ready one cycle after valid, data DEADBEEF status 00
    i_read = 1'b1; i_address = 8'h10;
    tick();
    i_read = 1'b0;
    chk("rd1.valid", o_bus_valid, 1);
    chk("rd1.access", o_bus_access, RD);
    chk("rd1.addr", o_bus_address, 8'h10);
    chk("rd1.waitreq", o_waitrequest, 1);
    tick();
    chk("rd1.valid_hold", o_bus_valid, 1);
    chk("rd1.no_early", o_readdatavalid, 0);
    i_bus_ready = 1'b1; i_bus_read_data = 32'hDEADBEEF; i_bus_status = 2'b00;
    tick();
    i_bus_ready = 1'b0; i_bus_read_data = 32'h0BADF00D;
    chk("rd1.rvalid", o_readdatavalid, 1);
    chk("rd1.wvalid", o_writeresponsevalid, 0);
    chk("rd1.rdata", o_readdata, 32'hDEADBEEF);
    chk("rd1.resp", o_response, 2'b00);
    chk("rd1.bus_valid_off", o_bus_valid, 0);
    tick();
    chk("rd1.pulse_end", o_readdatavalid, 0);
    chk("rd1.rdata_hold", o_readdata, 32'hDEADBEEF);

    // Write 0x24, data 12345678, be 0011, ready 5 cycles after valid
    i_write = 1'b1; i_address = 8'h24; i_writedata = 32'h12345678; i_byteenable = 4'b0011;
    tick();
    i_write = 1'b0; i_address = 8'hFF; i_writedata = 32'hFFFFFFFF; i_byteenable = 4'b1111;
    chk("wr1.access", o_bus_access, WR);
    chk("wr1.addr", o_bus_address, 8'h24);
    chk("wr1.wdata", o_bus_write_data, 32'h12345678);
    chk("wr1.strobe", o_bus_strobe, 4'b0011);
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("wr1.waitreq%0d", i), o_waitrequest, 1);
      chk($sformatf("wr1.nopulse%0d", i), o_writeresponsevalid, 0);
      if (i == 5) begin
        i_bus_ready = 1'b1; i_bus_status = 2'b00; i_bus_read_data = 32'h77777777;
      end
      tick();
    end
    i_bus_ready = 1'b0;
    chk("wr1.wvalid", o_writeresponsevalid, 1);
    chk("wr1.rvalid", o_readdatavalid, 0);
    chk("wr1.resp", o_response, 2'b00);
    chk("wr1.rdata_kept", o_readdata, 32'hDEADBEEF);
    chk("wr1.waitreq_off", o_waitrequest, 0);
    tick();
    chk("wr1.pulse_end", o_writeresponsevalid, 0);

    // Read with DECODEERROR status
    i_read = 1'b1; i_address = 8'h30;
    tick();
    i_read = 1'b0;
    i_bus_ready = 1'b1; i_bus_status = 2'b11; i_bus_read_data = 32'hCAFEF00D;
    tick();
    i_bus_ready = 1'b0;
    chk("rd3.rvalid", o_readdatavalid, 1);
    chk("rd3.resp", o_response, 2'b11);
    chk("rd3.rdata", o_readdata, 32'hCAFEF00D);
    tick();
    chk("rd3.resp_hold", o_response, 2'b11);

    // Read with EXOKAY passed through
    i_read = 1'b1; i_address = 8'h34;
    tick();
    i_read = 1'b0;
    i_bus_ready = 1'b1; i_bus_status = 2'b01; i_bus_read_data = 32'h00C0FFEE;
    tick();
    i_bus_ready = 1'b0;
    chk("exok.resp", o_response, 2'b01);
    chk("exok.rdata", o_readdata, 32'h00C0FFEE);
    tick();

    // Back-to-back: write 0x40 then read 0x44 presented continuously
    i_write = 1'b1; i_address = 8'h40; i_writedata = 32'hA0A0A0A0; i_byteenable = 4'b1111;
    tick();
    i_write = 1'b0; i_read = 1'b1; i_address = 8'h44;
    i_bus_ready = 1'b1; i_bus_status = 2'b00; i_bus_read_data = 32'h55AA55AA;
    chk("b2b.w_access", o_bus_access, WR);
    chk("b2b.stall", o_waitrequest, 1);
    tick();
    chk("b2b.wvalid", o_writeresponsevalid, 1);
    chk("b2b.waitreq_off", o_waitrequest, 0);
    tick();
    i_read = 1'b0;
    chk("b2b.r_access", o_bus_access, RD);
    chk("b2b.r_addr", o_bus_address, 8'h44);
    chk("b2b.r_valid", o_bus_valid, 1);
    chk("b2b.gap_w", o_writeresponsevalid, 0);
    chk("b2b.gap_r", o_readdatavalid, 0);
    tick();
    i_bus_ready = 1'b0;
    chk("b2b.rvalid", o_readdatavalid, 1);
    chk("b2b.rdata", o_readdata, 32'h55AA55AA);
    tick();
    chk("b2b.done_r", o_readdatavalid, 0);
    chk("b2b.done_w", o_writeresponsevalid, 0);

    // Read and write together: write wins
    i_read = 1'b1; i_write = 1'b1; i_address = 8'h50; i_writedata = 32'hA5A5A5A5;
    tick();
    i_read = 1'b0; i_write = 1'b0;
    chk("both.access", o_bus_access, WR);
    chk("both.wdata", o_bus_write_data, 32'hA5A5A5A5);
    i_bus_ready = 1'b1; i_bus_status = 2'b00; i_bus_read_data = 32'h11111111;
    tick();
    i_bus_ready = 1'b0;
    chk("both.wvalid", o_writeresponsevalid, 1);
    chk("both.rvalid", o_readdatavalid, 0);
    chk("both.rdata_kept", o_readdata, 32'h55AA55AA);
    tick();
    chk("both.idle", o_bus_valid, 0);

`ifdef RGGEN_AVALON_ADAPTER_TIMEOUT_EN
    // Timeout: read 0x60, ready never arrives
    i_read = 1'b1; i_address = 8'h60; i_bus_read_data = 32'h99999999;
    tick();
    i_read = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("to.busy%0d", i), o_bus_valid, 1);
      tick();
    end
    chk("to.valid_off", o_bus_valid, 0);
    chk("to.rvalid", o_readdatavalid, 1);
    chk("to.resp", o_response, 2'b10);
    chk("to.rdata", o_readdata, 0);
    tick();
    chk("to.pulse_end", o_readdatavalid, 0);
`else
    // Without the watchdog, BUSY persists while ready is absent
    i_read = 1'b1; i_address = 8'h60;
    tick();
    i_read = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    chk("nto.still_busy", o_bus_valid, 1);
    chk("nto.no_resp", o_readdatavalid, 0);
    i_rst_n = 1'b0;
    tick();
    i_rst_n = 1'b1;
    tick();
`endif

    // Reset asserted in the 2nd BUSY cycle aborts the transfer
    i_read = 1'b1; i_address = 8'h70;
    tick();
    i_read = 1'b0;
    tick();
    chk("abort.busy", o_bus_valid, 1);
    i_rst_n = 1'b0;
    #1;
    chk_reset_outputs("abort");
    tick();
    i_rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk($sformatf("abort.no_r%0d", i), o_readdatavalid, 0);
      chk($sformatf("abort.no_v%0d", i), o_bus_valid, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
